cma_tap_engine: RTL

//  Sequential CMA coefficient-update engine for an N_TAPS equaliser.

---
 rtl/cma_tap_engine_if.sv | 30 +++
 rtl/cma_tap_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cma_tap_engine_if.sv
// Handshake, operand and coefficient bus of the CMA tap-update engine.
// The master side (FIR / error calculator / host) drives requests and loads; the engine is the slave.
interface cma_tap_engine_if #(
    parameter int NB_I   = 18,
    parameter int NB     = 8,
    parameter int NB_MU  = 16,
    parameter int N_TAPS = 8
);
    logic                     i_valid;
    logic                     o_ready;
    logic [N_TAPS*NB_I-1:0]   i_x_vec;
    logic [NB_I-1:0]          i_fir_out;
    logic [NB-1:0]            i_error;
    logic [NB_MU-1:0]         i_mu;
    logic                     i_load;
    logic [N_TAPS*NB-1:0]     i_w_init;
    logic [N_TAPS*NB-1:0]     o_w_vec;
    logic                     o_done;
    logic [7:0]               o_sat_cnt;

    modport master (
        output i_valid, i_x_vec, i_fir_out, i_error, i_mu, i_load, i_w_init,
        input  o_ready, o_w_vec, o_done, o_sat_cnt
    );

    modport slave (
        input  i_valid, i_x_vec, i_fir_out, i_error, i_mu, i_load, i_w_init,
        output o_ready, o_w_vec, o_done, o_sat_cnt
    );
endinterface

// File: rtl/cma_tap_engine.sv
// Sequential CMA coefficient updater: w[k] -= mu*e*y*x[k], N_PAR taps per cycle, with an
// internal working bank and a committed copy that only changes on DONE or on an idle load.
module cma_tap_engine #(
    parameter int NB_I   = 18,
    parameter int NBF_I  = 15,
    parameter int NB     = 8,
    parameter int NBF    = 7,
    parameter int NB_MU  = 16,
    parameter int N_TAPS = 8,
    parameter int N_PAR  = 1,
    parameter int CENTER = 4,
    parameter int ROUND  = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    cma_tap_engine_if.slave    bus
);
    localparam int N_GROUPS = N_TAPS / N_PAR;
    localparam int G_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int IDX_W    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int M_W      = NB_I + NB + NB_MU;
    localparam int UPD_W    = M_W + NB_I;
    // Fractional bits of the update minus fractional bits of a coefficient.
    localparam int SHIFT    = (NBF_I + NBF + NB_MU - 1 + NBF_I) - NBF;
    localparam int DIFF_W   = UPD_W + 2;

    localparam logic signed [NB-1:0]     W_MAX = {1'b0, {(NB-1){1'b1}}};
    localparam logic signed [NB-1:0]     W_MIN = {1'b1, {(NB-1){1'b0}}};
    localparam logic signed [DIFF_W-1:0] HALF  = {{(DIFF_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_UPD, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [G_W-1:0]         g_reg, g_next;
    logic signed [NB-1:0]   bank_reg [N_TAPS];
    logic signed [NB-1:0]   wout_reg [N_TAPS];
    logic signed [NB_I-1:0] x_reg [N_TAPS];
    logic signed [NB_I-1:0] y_reg;
    logic signed [NB-1:0]   e_reg;
    logic signed [NB_MU-1:0] mu_reg;
    logic signed [M_W-1:0]  m_reg;
    logic [7:0]             sat_cnt_reg, sat_cnt_next;
    logic [8:0]             sat_sum;

    logic [IDX_W-1:0]       lane_idx [N_PAR];
    logic signed [NB-1:0]   lane_w   [N_PAR];
    logic [N_PAR-1:0]       lane_sat;

    logic accept, load_en;
    assign accept  = (state_reg == S_IDLE) && bus.i_valid;
    assign load_en = (state_reg == S_IDLE) && bus.i_load && !bus.i_valid;

    assign bus.o_ready   = (state_reg == S_IDLE);
    assign bus.o_done    = (state_reg == S_DONE);
    assign bus.o_sat_cnt = sat_cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_IDLE;
            g_reg     <= '0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        case (state_reg)
            S_IDLE: if (bus.i_valid) state_next = S_PREP;
            S_PREP: begin
                state_next = S_UPD;
                g_next     = '0;
            end
            S_UPD: begin
                if (g_reg == G_W'(N_GROUPS - 1)) begin
                    g_next     = '0;
                    state_next = S_DONE;
                end else begin
                    g_next = g_reg + 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // One datapath lane per tap updated in parallel within the current group.
    generate
        for (genvar gi = 0; gi < N_PAR; gi++) begin : g_lane
            logic [IDX_W-1:0]        idx;
            logic signed [NB_I-1:0]  x_l;
            logic signed [NB-1:0]    w_l;
            logic signed [UPD_W-1:0] upd;
            logic signed [DIFF_W-1:0] w_ext, upd_ext, diff, diff_r, q_full;
            logic                    ovf;

            assign idx     = IDX_W'(g_reg) * IDX_W'(N_PAR) + IDX_W'(gi);
            assign x_l     = x_reg[idx];
            assign w_l     = bank_reg[idx];
            assign upd     = m_reg * x_l;
            assign w_ext   = {{(DIFF_W-NB-SHIFT){w_l[NB-1]}}, w_l, {SHIFT{1'b0}}};
            assign upd_ext = {{(DIFF_W-UPD_W){upd[UPD_W-1]}}, upd};
            assign diff    = w_ext - upd_ext;
            assign diff_r  = (ROUND != 0) ? diff + HALF : diff;
            assign q_full  = diff_r >>> SHIFT;
            // In range only when every bit above the result sign matches it.
            assign ovf     = !((&q_full[DIFF_W-1:NB-1]) || (~|q_full[DIFF_W-1:NB-1]));

            assign lane_idx[gi] = idx;
            assign lane_sat[gi] = ovf;
            assign lane_w[gi]   = ovf ? (q_full[DIFF_W-1] ? W_MIN : W_MAX) : q_full[NB-1:0];
        end

        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_out
            assign bus.o_w_vec[gi*NB +: NB] = wout_reg[gi];
        end
    endgenerate

    always_comb begin
        sat_sum = {1'b0, sat_cnt_reg};
        for (int p = 0; p < N_PAR; p++) begin
            sat_sum = sat_sum + 9'(lane_sat[p]);
        end
        sat_cnt_next = (sat_sum > 9'd255) ? 8'hFF : sat_sum[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                bank_reg[k] <= (k == CENTER) ? W_MAX : '0;
                wout_reg[k] <= (k == CENTER) ? W_MAX : '0;
                x_reg[k]    <= '0;
            end
            y_reg       <= '0;
            e_reg       <= '0;
            mu_reg      <= '0;
            m_reg       <= '0;
            sat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < N_TAPS; k++) begin
                            x_reg[k] <= bus.i_x_vec[k*NB_I +: NB_I];
                        end
                        y_reg  <= bus.i_fir_out;
                        e_reg  <= bus.i_error;
                        mu_reg <= bus.i_mu;
                    end else if (load_en) begin
                        for (int k = 0; k < N_TAPS; k++) begin
                            bank_reg[k] <= bus.i_w_init[k*NB +: NB];
                            wout_reg[k] <= bus.i_w_init[k*NB +: NB];
                        end
                    end
                end
                S_PREP: begin
                    m_reg       <= y_reg * e_reg * mu_reg;
                    sat_cnt_reg <= '0;
                end
                S_UPD: begin
                    for (int p = 0; p < N_PAR; p++) begin
                        bank_reg[lane_idx[p]] <= lane_w[p];
                    end
                    sat_cnt_reg <= sat_cnt_next;
                end
                S_DONE: begin
                    for (int k = 0; k < N_TAPS; k++) begin
                        wout_reg[k] <= bank_reg[k];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
